draw_ball: RTL

- Overlays the 16x16 ball sprite onto the incoming VGA pixel stream.
- Sits between the background/paddle draw stage and the VGA output.
- Generates the 8-bit sprite ROM address from the pixel counters and the ball position, then consumes the registered 12-bit colour that the ball ROM returns.
- Delays all timing signals so they stay aligned with the ROM latency.

---
 rtl/draw_ball_if.sv | 37 +++
 rtl/draw_ball.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/draw_ball_if.sv
// rtl/draw_ball_if.sv - video stream, ball position and sprite ROM bundle for draw_ball
interface draw_ball_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [11:0] rom_rgb;
  logic [7:0]  rom_addr;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  // Upstream draw stage, position source and ROM side
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, rom_rgb,
    input  rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out
  );

  // Ball overlay stage
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, rom_rgb,
    output rom_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_ball.sv
// rtl/draw_ball.sv - overlays the 16x16 ball sprite onto the VGA pixel stream
module draw_ball #(
  parameter int          BALL_SIZE    = 16,
  parameter logic [11:0] TRANSP_COLOR = 12'h000,
  parameter bit          TRANSP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  draw_ball_if.slave  vid
);

  localparam logic [12:0] SIZE13 = 13'(BALL_SIZE);

  // Position latched once per frame so the ball never tears mid-frame
  logic        vblnk_prev;
  logic [11:0] x_lat;
  logic [11:0] y_lat;

  // Stage 1 and stage 2 delay line
  logic [10:0] s1_hcount, s2_hcount;
  logic [10:0] s1_vcount, s2_vcount;
  logic        s1_hsync, s2_hsync;
  logic        s1_vsync, s2_vsync;
  logic        s1_hblnk, s2_hblnk;
  logic        s1_vblnk, s2_vblnk;
  logic [11:0] s1_rgb, s2_rgb;
  logic        s1_in_box, s2_in_box;

  // Box test is done at 13 bits so x_lat+16 cannot wrap near the 12-bit limit
  logic [12:0] h13, v13, x13, y13;
  logic        in_box;
  logic [3:0]  dx4, dy4;
  logic        transparent;
  logic        vblnk_rise;

  assign h13 = {2'b00, vid.hcount_in};
  assign v13 = {2'b00, vid.vcount_in};
  assign x13 = {1'b0, x_lat};
  assign y13 = {1'b0, y_lat};

  assign in_box = (h13 >= x13) && (h13 < x13 + SIZE13) &&
                  (v13 >= y13) && (v13 < y13 + SIZE13);

  // Only the low nibble of the offset addresses the ROM; it equals the low
  // nibble of the full-width difference
  assign dx4 = vid.hcount_in[3:0] - x_lat[3:0];
  assign dy4 = vid.vcount_in[3:0] - y_lat[3:0];

  assign transparent = TRANSP_EN && (vid.rom_rgb == TRANSP_COLOR);
  assign vblnk_rise  = vid.vblnk_in && !vblnk_prev;

  // Latch ball position on the vblank rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      vblnk_prev <= vid.vblnk_in;
      if (vblnk_rise) begin
        x_lat <= vid.xpos;
        y_lat <= vid.ypos;
      end
    end
  end

  // Stage 1: ROM address generation and first delay slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.rom_addr <= '0;
      s1_hcount    <= '0;
      s1_vcount    <= '0;
      s1_hsync     <= 1'b0;
      s1_vsync     <= 1'b0;
      s1_hblnk     <= 1'b0;
      s1_vblnk     <= 1'b0;
      s1_rgb       <= '0;
      s1_in_box    <= 1'b0;
    end else begin
      vid.rom_addr <= {dy4, dx4};
      s1_hcount    <= vid.hcount_in;
      s1_vcount    <= vid.vcount_in;
      s1_hsync     <= vid.hsync_in;
      s1_vsync     <= vid.vsync_in;
      s1_hblnk     <= vid.hblnk_in;
      s1_vblnk     <= vid.vblnk_in;
      s1_rgb       <= vid.rgb_in;
      s1_in_box    <= in_box;
    end
  end

  // Stage 2: pure delay while the ROM registers its colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_hcount <= '0;
      s2_vcount <= '0;
      s2_hsync  <= 1'b0;
      s2_vsync  <= 1'b0;
      s2_hblnk  <= 1'b0;
      s2_vblnk  <= 1'b0;
      s2_rgb    <= '0;
      s2_in_box <= 1'b0;
    end else begin
      s2_hcount <= s1_hcount;
      s2_vcount <= s1_vcount;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
      s2_hblnk  <= s1_hblnk;
      s2_vblnk  <= s1_vblnk;
      s2_rgb    <= s1_rgb;
      s2_in_box <= s1_in_box;
    end
  end

  // Stage 3: composite sprite over background, black during blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hcount_out <= '0;
      vid.vcount_out <= '0;
      vid.hsync_out  <= 1'b0;
      vid.vsync_out  <= 1'b0;
      vid.hblnk_out  <= 1'b0;
      vid.vblnk_out  <= 1'b0;
      vid.rgb_out    <= '0;
    end else begin
      vid.hcount_out <= s2_hcount;
      vid.vcount_out <= s2_vcount;
      vid.hsync_out  <= s2_hsync;
      vid.vsync_out  <= s2_vsync;
      vid.hblnk_out  <= s2_hblnk;
      vid.vblnk_out  <= s2_vblnk;
      if (s2_hblnk || s2_vblnk)
        vid.rgb_out <= 12'h000;
      else if (s2_in_box && !transparent)
        vid.rgb_out <= vid.rom_rgb;
      else
        vid.rgb_out <= s2_rgb;
    end
  end

endmodule
